// File: rtl/butterfly_r2_pipe.sv
// butterfly_r2_pipe
//   Pipelined radix-2 DIT butterfly for a fixed-point complex FFT stage:
//     X = A + W*B,  Y = A - W*B
//   with optional conjugated twiddle (inverse FFT), optional divide-by-two
//   with round-half-up, saturation, and a sticky overflow flag.
//   The latency is 3 cycles and the throughput is one beat per cycle. A single
//   enable freezes the whole pipe when the output is stalled.
//
// Ports
//   clk, rst                 clock (rising edge), asynchronous active-high reset
//   in_valid / in_ready      input handshake (in_ready = pipe enable)
//   a_re, a_im, b_re, b_im   operands, signed Q1.(DW-1)
//   w_re, w_im               twiddle, signed Q1.(TW-1)
//   inv, scale               per-beat mode bits, travel with the beat
//   out_valid / out_ready    output handshake
//   x_re, x_im, y_re, y_im   results, signed Q1.(DW-1)
//   ovf, ovf_clr             sticky saturation flag and its synchronous clear
module butterfly_r2_pipe #(
  parameter int DW = 16,
  parameter int TW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] a_re,
  input  logic [DW-1:0] a_im,
  input  logic [DW-1:0] b_re,
  input  logic [DW-1:0] b_im,
  input  logic [TW-1:0] w_re,
  input  logic [TW-1:0] w_im,
  input  logic          inv,
  input  logic          scale,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] x_re,
  output logic [DW-1:0] x_im,
  output logic [DW-1:0] y_re,
  output logic [DW-1:0] y_im,
  output logic          ovf,
  input  logic          ovf_clr
);

  localparam int PW = DW + TW;  // raw product width
  localparam int SW = PW + 1;   // complex-product sum width
  localparam int RW = DW + 1;   // rounded W*B width
  localparam int OW = DW + 2;   // butterfly sum width
  localparam logic signed [SW-1:0] RND = SW'(1) <<< (TW - 2);

  logic en;

  // Stage 1: raw partial products plus A and the mode bits.
  logic signed [PW-1:0] p_rr_d, p_ii_d, p_ir_d, p_ri_d;
  logic signed [PW-1:0] p_rr_q, p_ii_q, p_ir_q, p_ri_q;
  logic [1:0][DW-1:0]   a1_q;
  logic                 v1_q, inv1_q, scale1_q;

  // Stage 2: rounded complex product t = W*B (or conj(W)*B).
  logic signed [SW-1:0] sum_d [2];
  logic [1:0][RW-1:0]   t2_d, t2_q;
  logic [1:0]           sat2_lane;
  logic [1:0][DW-1:0]   a2_q;
  logic                 v2_q, scale2_q, sat2_q;

  // Stage 3: outputs, index 0 = x_re, 1 = x_im, 2 = y_re, 3 = y_im.
  logic [3:0][DW-1:0]   out_d, out_q;
  logic [3:0]           sat3_lane;
  logic                 v3_q, ovf_q, ovf_set;

  // A stalled output freezes every stage, so bubbles are never squeezed out.
  assign en       = !v3_q | out_ready;
  assign in_ready = en;

  assign p_rr_d = PW'($signed(b_re)) * PW'($signed(w_re));
  assign p_ii_d = PW'($signed(b_im)) * PW'($signed(w_im));
  assign p_ir_d = PW'($signed(b_im)) * PW'($signed(w_re));
  assign p_ri_d = PW'($signed(b_re)) * PW'($signed(w_im));

  // Conjugating W only flips the sign of the w_im terms.
  assign sum_d[0] = inv1_q ? (SW'(p_rr_q) + SW'(p_ii_q)) : (SW'(p_rr_q) - SW'(p_ii_q));
  assign sum_d[1] = inv1_q ? (SW'(p_ir_q) - SW'(p_ri_q)) : (SW'(p_ir_q) + SW'(p_ri_q));

  for (genvar gi = 0; gi < 2; gi++) begin : g_s2
    logic signed [SW-1:0] rnd, shf;
    assign rnd = sum_d[gi] + RND;
    assign shf = rnd >>> (TW - 1);
    // Only W = (-1,-1)-like corners can exceed DW+1 bits here.
    assign sat2_lane[gi] = (shf[SW-1:DW] != {(SW-DW){shf[SW-1]}});
    assign t2_d[gi] = sat2_lane[gi] ? {shf[SW-1], {DW{~shf[SW-1]}}} : shf[RW-1:0];
  end

  for (genvar gi = 0; gi < 4; gi++) begin : g_s3
    logic signed [OW-1:0] a_ext, t_ext, sum, scl;
    assign a_ext = OW'($signed(a2_q[gi % 2]));
    assign t_ext = OW'($signed(t2_q[gi % 2]));
    if (gi < 2) begin : g_add
      assign sum = a_ext + t_ext;
    end else begin : g_sub
      assign sum = a_ext - t_ext;
    end
    // Round half up before halving.
    assign scl = scale2_q ? ((sum + OW'(1)) >>> 1) : sum;
    assign sat3_lane[gi] = (scl[OW-1:DW-1] != {(OW-DW+1){scl[OW-1]}});
    assign out_d[gi] = sat3_lane[gi] ? {scl[OW-1], {(DW-1){~scl[OW-1]}}} : scl[DW-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1_q     <= 1'b0;
      inv1_q   <= 1'b0;
      scale1_q <= 1'b0;
      a1_q     <= '0;
      p_rr_q   <= '0;
      p_ii_q   <= '0;
      p_ir_q   <= '0;
      p_ri_q   <= '0;
      v2_q     <= 1'b0;
      scale2_q <= 1'b0;
      sat2_q   <= 1'b0;
      a2_q     <= '0;
      t2_q     <= '0;
      v3_q     <= 1'b0;
      out_q    <= '0;
    end else if (en) begin
      v1_q     <= in_valid;
      inv1_q   <= inv;
      scale1_q <= scale;
      a1_q     <= {a_im, a_re};
      p_rr_q   <= p_rr_d;
      p_ii_q   <= p_ii_d;
      p_ir_q   <= p_ir_d;
      p_ri_q   <= p_ri_d;
      v2_q     <= v1_q;
      scale2_q <= scale1_q;
      sat2_q   <= |sat2_lane;
      a2_q     <= a1_q;
      t2_q     <= t2_d;
      v3_q     <= v2_q;
      out_q    <= out_d;
    end
  end

  // Only a valid beat actually landing in the output register may set ovf.
  assign ovf_set = en & v2_q & (sat2_q | (|sat3_lane));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_set | (ovf_q & ~ovf_clr);
    end
  end

  assign out_valid = v3_q;
  assign x_re      = out_q[0];
  assign x_im      = out_q[1];
  assign y_re      = out_q[2];
  assign y_im      = out_q[3];
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_butterfly_r2_pipe.sv
// Self-checking bench for butterfly_r2_pipe: directed corner beats, a
// backpressure burst, ovf clear behaviour, reset mid-flight, then a long
// random regression scored against an integer reference model.
module tb_butterfly_r2_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic [15:0] a_re, a_im, b_re, b_im, w_re, w_im;
  logic        inv, scale;
  logic        out_valid, out_ready;
  logic [15:0] x_re, x_im, y_re, y_im;
  logic        ovf, ovf_clr;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [15:0] xr, xi, yr, yi;
    bit          sat;
  } exp_t;

  exp_t q[$];
  bit   seen_sat;
  int   delivered;

  butterfly_r2_pipe dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .a_re(a_re), .a_im(a_im), .b_re(b_re), .b_im(b_im),
    .w_re(w_re), .w_im(w_im), .inv(inv), .scale(scale),
    .out_valid(out_valid), .out_ready(out_ready),
    .x_re(x_re), .x_im(x_im), .y_re(y_re), .y_im(y_im),
    .ovf(ovf), .ovf_clr(ovf_clr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic longint clip(input longint v, input longint lo, input longint hi, inout bit s);
    if (v > hi) begin s = 1'b1; return hi; end
    if (v < lo) begin s = 1'b1; return lo; end
    return v;
  endfunction

  // Reference: complex arithmetic on plain integers, following the rounding,
  // scaling and saturation rules of the block.
  function automatic exp_t model(input logic [15:0] ar, ai, br, bi, wr, wi, input logic iv, sc);
    exp_t   m;
    bit     s = 1'b0;
    longint rr, ii, ir, ri, tre, tim, xr, xi, yr, yi;
    rr  = longint'($signed(br)) * longint'($signed(wr));
    ii  = longint'($signed(bi)) * longint'($signed(wi));
    ir  = longint'($signed(bi)) * longint'($signed(wr));
    ri  = longint'($signed(br)) * longint'($signed(wi));
    tre = iv ? rr + ii : rr - ii;
    tim = iv ? ir - ri : ir + ri;
    tre = clip((tre + 16384) >>> 15, -65536, 65535, s);
    tim = clip((tim + 16384) >>> 15, -65536, 65535, s);
    xr  = longint'($signed(ar)) + tre;
    xi  = longint'($signed(ai)) + tim;
    yr  = longint'($signed(ar)) - tre;
    yi  = longint'($signed(ai)) - tim;
    if (sc) begin
      xr = (xr + 1) >>> 1;
      xi = (xi + 1) >>> 1;
      yr = (yr + 1) >>> 1;
      yi = (yi + 1) >>> 1;
    end
    xr = clip(xr, -32768, 32767, s);
    xi = clip(xi, -32768, 32767, s);
    yr = clip(yr, -32768, 32767, s);
    yi = clip(yi, -32768, 32767, s);
    m.xr = xr[15:0];
    m.xi = xi[15:0];
    m.yr = yr[15:0];
    m.yi = yi[15:0];
    m.sat = s;
    return m;
  endfunction

  // One clock: score handshakes seen before the edge, then check the outputs
  // and the ovf flag against the model state after the edge.
  task automatic tick();
    bit   acc, fire, ld, clr;
    exp_t e;
    #1;
    acc  = in_valid && in_ready;
    fire = out_valid && out_ready;
    ld   = !out_valid || out_ready;
    clr  = ovf_clr;
    if (acc) e = model(a_re, a_im, b_re, b_im, w_re, w_im, inv, scale);
    @(posedge clk);
    #1;
    if (fire && q.size() > 0) begin
      void'(q.pop_front());
      delivered++;
    end
    if (acc) q.push_back(e);
    if (clr) seen_sat = 1'b0;
    if (out_valid) begin
      if (q.size() == 0) begin
        chk("spurious_out", {31'b0, out_valid}, 32'd0);
      end else begin
        chk("x_re", {16'b0, x_re}, {16'b0, q[0].xr});
        chk("x_im", {16'b0, x_im}, {16'b0, q[0].xi});
        chk("y_re", {16'b0, y_re}, {16'b0, q[0].yr});
        chk("y_im", {16'b0, y_im}, {16'b0, q[0].yi});
        if (ld && q[0].sat) seen_sat = 1'b1;
      end
    end
    chk("ovf_track", {31'b0, ovf}, {31'b0, seen_sat});
  endtask

  task automatic set_beat(input logic [15:0] ar, ai, br, bi, wr, wi, input logic iv, sc);
    a_re = ar; a_im = ai; b_re = br; b_im = bi; w_re = wr; w_im = wi;
    inv = iv; scale = sc; in_valid = 1'b1;
  endtask

  // Accept one beat and advance until it sits in the output register.
  task automatic one_beat(input logic [15:0] ar, ai, br, bi, wr, wi, input logic iv, sc);
    set_beat(ar, ai, br, bi, wr, wi, iv, sc);
    tick();
    in_valid = 1'b0;
    tick();
    chk("latency_early", {31'b0, out_valid}, 32'd0);
    tick();
    chk("latency_3", {31'b0, out_valid}, 32'd1);
    $display("beat a=(%h,%h) b=(%h,%h) w=(%h,%h) inv=%0d scale=%0d -> x=(%h,%h) y=(%h,%h) ovf=%0d",
             ar, ai, br, bi, wr, wi, iv, sc, x_re, x_im, y_re, y_im, ovf);
  endtask

  int          sent, acc_n, cyc;
  logic [15:0] hold [4];

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; ovf_clr = 1'b0;
    inv = 1'b0; scale = 1'b0;
    a_re = '0; a_im = '0; b_re = '0; b_im = '0; w_re = '0; w_im = '0;
    seen_sat = 1'b0; delivered = 0;

    #12;
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
    chk("rst_ovf", {31'b0, ovf}, 32'd0);
    chk("rst_x", {x_re, x_im}, 32'd0);
    chk("rst_y", {y_re, y_im}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Pass-through with W = +1.0
    one_beat(16'h2000, 16'h0000, 16'h1000, 16'h0000, 16'h7FFF, 16'h0000, 1'b0, 1'b0);
    chk("t1_x", {x_re, x_im}, 32'h3000_0000);
    chk("t1_y", {y_re, y_im}, 32'h1000_0000);
    chk("t1_ovf", {31'b0, ovf}, 32'd0);
    tick();

    // Rotation by +j, then by conj (-j)
    one_beat(16'h0000, 16'h0000, 16'h1000, 16'h0000, 16'h0000, 16'h7FFF, 1'b0, 1'b0);
    chk("t2_x", {x_re, x_im}, 32'h0000_1000);
    chk("t2_y", {y_re, y_im}, 32'h0000_F000);
    tick();
    one_beat(16'h0000, 16'h0000, 16'h1000, 16'h0000, 16'h0000, 16'h7FFF, 1'b1, 1'b0);
    chk("t2i_x", {x_re, x_im}, 32'h0000_F000);
    chk("t2i_y", {y_re, y_im}, 32'h0000_1000);
    tick();

    // Saturation, then the same beat halved
    one_beat(16'h7000, 16'h0000, 16'h7000, 16'h0000, 16'h7FFF, 16'h0000, 1'b0, 1'b0);
    chk("t3_x_re", {16'b0, x_re}, 32'h7FFF);
    chk("t3_y_re", {16'b0, y_re}, 32'h0001);
    chk("t3_ovf", {31'b0, ovf}, 32'd1);
    tick();
    one_beat(16'h7000, 16'h0000, 16'h7000, 16'h0000, 16'h7FFF, 16'h0000, 1'b0, 1'b1);
    chk("t3s_x_re", {16'b0, x_re}, 32'h7000);
    chk("t3s_y_re", {16'b0, y_re}, 32'h0001);
    chk("t3s_ovf", {31'b0, ovf}, 32'd1);
    tick();

    // Backpressure: 8 streamed beats, out_ready low for cycles 4-7
    sent = 0;
    delivered = 0;
    for (int k = 0; k < 20; k++) begin
      out_ready = !(k >= 4 && k <= 7);
      if (sent < 8) begin
        set_beat(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom),
                 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
      end else begin
        in_valid = 1'b0;
      end
      #1;
      chk("bp_in_ready", {31'b0, in_ready}, {31'b0, !(k >= 4 && k <= 7)});
      if (k == 4) begin
        hold[0] = x_re; hold[1] = x_im; hold[2] = y_re; hold[3] = y_im;
      end
      if (k > 4 && k <= 7) begin
        chk("bp_hold", {x_re, x_im, y_re, y_im} == {hold[0], hold[1], hold[2], hold[3]} ? 32'd1 : 32'd0, 32'd1);
        chk("bp_hold_valid", {31'b0, out_valid}, 32'd1);
      end
      if (in_valid && in_ready) sent++;
      tick();
    end
    $display("backpressure burst: sent=%0d delivered=%0d", sent, delivered);
    chk("bp_sent", sent, 32'd8);
    chk("bp_delivered", delivered, 32'd8);
    chk("bp_drained", q.size(), 32'd0);
    out_ready = 1'b1;

    // ovf_clr coinciding with a saturating load: set wins
    set_beat(16'h7000, 16'h0000, 16'h7000, 16'h0000, 16'h7FFF, 16'h0000, 1'b0, 1'b0);
    tick();
    in_valid = 1'b0;
    tick();
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    chk("t5_set_wins", {31'b0, ovf}, 32'd1);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    chk("t5_clear", {31'b0, ovf}, 32'd0);
    $display("ovf clear sequence done: ovf=%0d", ovf);
    tick();

    // Reset with three beats in flight
    for (int k = 0; k < 3; k++) begin
      set_beat(16'h7000, 16'h0100, 16'h7000, 16'h0200, 16'h7FFF, 16'h0010, 1'b0, 1'b0);
      tick();
    end
    in_valid = 1'b0;
    chk("t6_pre_valid", {31'b0, out_valid}, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("t6_rst_valid", {31'b0, out_valid}, 32'd0);
    chk("t6_rst_x", {x_re, x_im}, 32'd0);
    chk("t6_rst_y", {y_re, y_im}, 32'd0);
    chk("t6_rst_ovf", {31'b0, ovf}, 32'd0);
    q.delete();
    seen_sat = 1'b0;
    @(posedge clk); #3;
    rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("t6_quiet", {31'b0, out_valid}, 32'd0);
    end
    one_beat(16'h0100, 16'h0000, 16'h0100, 16'h0000, 16'h7FFF, 16'h0000, 1'b0, 1'b0);
    chk("t6_new_x_re", {16'b0, x_re}, 32'h0200);
    tick();

    // Random regression
    acc_n = 0;
    cyc = 0;
    while (acc_n < 10000 && cyc < 60000) begin
      in_valid  = ($urandom_range(0, 9) < 8);
      a_re = 16'($urandom); a_im = 16'($urandom);
      b_re = 16'($urandom); b_im = 16'($urandom);
      w_re = 16'($urandom); w_im = 16'($urandom);
      inv = 1'($urandom); scale = 1'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      ovf_clr   = ($urandom_range(0, 49) == 0);
      #1;
      if (in_valid && in_ready) acc_n++;
      tick();
      cyc++;
    end
    chk("rand_beats", acc_n, 32'd10000);
    in_valid = 1'b0;
    out_ready = 1'b1;
    ovf_clr = 1'b0;
    repeat (8) tick();
    chk("rand_drained", q.size(), 32'd0);
    $display("random regression: %0d beats in %0d cycles", acc_n, cyc);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
